// File: rtl/uart_rx_ctrl.sv
// uart_rx_ctrl: receive-side sequencer for the UART RX path.
// It detects the start bit, runs the oversample edge counter and the bit
// counter, fires the sampler/checker enables at the last edge of each bit,
// deserializes the payload LSB-first and reports the frame outcome with
// single-cycle pulses.
module uart_rx_ctrl #(
  parameter int DATA_WIDTH = 8,
  parameter int PRESCALE_W = 6
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  RX_IN,
  input  logic                  PAR_EN,
  input  logic [PRESCALE_W-1:0] PRESCALE,
  input  logic                  SAMPLED_BIT,
  input  logic                  STRT_GLITCH,
  input  logic                  PAR_ERR,
  input  logic                  STP_ERR,
  output logic [PRESCALE_W-1:0] EDGE_CNT,
  output logic [3:0]            BIT_CNT,
  output logic                  DAT_SAMP_EN,
  output logic                  STRT_CHK_EN,
  output logic                  PAR_CHK_EN,
  output logic                  STP_CHK_EN,
  output logic [DATA_WIDTH-1:0] P_DATA,
  output logic                  DATA_VALID,
  output logic                  PAR_ERR_FLAG,
  output logic                  FRM_ERR_FLAG
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  localparam logic [PRESCALE_W-1:0] PRESCALE_DEF = PRESCALE_W'(8);
  localparam logic [3:0]            BIT_LAST     = 4'(DATA_WIDTH);

  state_t                  state;
  state_t                  state_next;
  logic [PRESCALE_W-1:0]   prescale_lat;  // oversampling ratio frozen for the frame
  logic                    par_en_lat;    // parity mode frozen for the frame
  logic                    par_fail;      // parity check failed in this frame
  logic                    prescale_ok;
  logic                    last_edge;

  // Only 8, 16 and 32 are supported ratios; anything else runs at 8.
  assign prescale_ok = (PRESCALE == PRESCALE_W'(8))  ||
                       (PRESCALE == PRESCALE_W'(16)) ||
                       (PRESCALE == PRESCALE_W'(32));

  // Last oversample edge of the current bit: all strobes and shifts happen here.
  assign last_edge = (EDGE_CNT == prescale_lat - PRESCALE_W'(1));

  // Sampler runs for the whole frame, from the start bit through the stop bit.
  assign DAT_SAMP_EN = (state != IDLE);

  // State register.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples the
  // pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state decode and the single-cycle checker strobes.
  // NOTE: every output of this block gets a default first, so no path leaves a
  // signal unassigned and no latch is inferred.
  always_comb begin
    state_next  = state;
    STRT_CHK_EN = 1'b0;
    PAR_CHK_EN  = 1'b0;
    STP_CHK_EN  = 1'b0;
    case (state)
      IDLE: begin
        if (!RX_IN) begin
          state_next = START;
        end
      end
      START: begin
        if (last_edge) begin
          STRT_CHK_EN = 1'b1;
          state_next  = STRT_GLITCH ? IDLE : DATA;
        end
      end
      DATA: begin
        if (last_edge && (BIT_CNT == BIT_LAST)) begin
          state_next = par_en_lat ? PARITY : STOP;
        end
      end
      PARITY: begin
        if (last_edge) begin
          PAR_CHK_EN = 1'b1;
          state_next = STOP;
        end
      end
      STOP: begin
        if (last_edge) begin
          STP_CHK_EN = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Counters, frame configuration latch, deserializer and outcome pulses.
  always_ff @(posedge CLK) begin
    if (RST) begin
      EDGE_CNT     <= '0;
      BIT_CNT      <= '0;
      P_DATA       <= '0;
      DATA_VALID   <= 1'b0;
      PAR_ERR_FLAG <= 1'b0;
      FRM_ERR_FLAG <= 1'b0;
      par_fail     <= 1'b0;
      prescale_lat <= PRESCALE_DEF;
      par_en_lat   <= 1'b0;
    end else begin
      DATA_VALID   <= 1'b0;
      PAR_ERR_FLAG <= 1'b0;
      FRM_ERR_FLAG <= 1'b0;

      if (state == IDLE) begin
        // The detect cycle is edge 0 of the start bit, so counting resumes at 1.
        BIT_CNT <= '0;
        if (!RX_IN) begin
          EDGE_CNT     <= PRESCALE_W'(1);
          prescale_lat <= prescale_ok ? PRESCALE : PRESCALE_DEF;
          par_en_lat   <= PAR_EN;
        end else begin
          EDGE_CNT <= '0;
        end
      end else if (state_next == IDLE) begin
        // Frame end or start glitch: park both counters.
        EDGE_CNT <= '0;
        BIT_CNT  <= '0;
      end else if (last_edge) begin
        EDGE_CNT <= '0;
        BIT_CNT  <= BIT_CNT + 4'd1;
      end else begin
        EDGE_CNT <= EDGE_CNT + PRESCALE_W'(1);
      end

      // Right shift in at the MSB so the first data bit lands in P_DATA[0].
      if ((state == DATA) && last_edge) begin
        P_DATA <= {SAMPLED_BIT, P_DATA[DATA_WIDTH-1:1]};
      end

      if (PAR_CHK_EN && PAR_ERR) begin
        par_fail <= 1'b1;
      end

      if (STP_CHK_EN) begin
        DATA_VALID   <= !par_fail && !STP_ERR;
        PAR_ERR_FLAG <= par_fail;
        FRM_ERR_FLAG <= STP_ERR;
        par_fail     <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// tb_uart_rx_ctrl: self-checking bench for uart_rx_ctrl. The bench plays the
// data sampler and the three checkers, and predicts every output from the
// frame timeline: for a frame that starts at cycle t, cycle offset o belongs
// to bit o/P at edge o%P, and the frame result shows at offset 10P or 11P.
module tb_uart_rx_ctrl;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       RX_IN = 1'b1;
  logic       PAR_EN = 1'b0;
  logic [5:0] PRESCALE = 6'd8;
  logic       SAMPLED_BIT = 1'b0;
  logic       STRT_GLITCH = 1'b0;
  logic       PAR_ERR = 1'b0;
  logic       STP_ERR = 1'b0;
  logic [5:0] EDGE_CNT;
  logic [3:0] BIT_CNT;
  logic       DAT_SAMP_EN;
  logic       STRT_CHK_EN;
  logic       PAR_CHK_EN;
  logic       STP_CHK_EN;
  logic [7:0] P_DATA;
  logic       DATA_VALID;
  logic       PAR_ERR_FLAG;
  logic       FRM_ERR_FLAG;

  uart_rx_ctrl #(
    .DATA_WIDTH(8),
    .PRESCALE_W(6)
  ) dut (
    .CLK         (CLK),
    .RST         (RST),
    .RX_IN       (RX_IN),
    .PAR_EN      (PAR_EN),
    .PRESCALE    (PRESCALE),
    .SAMPLED_BIT (SAMPLED_BIT),
    .STRT_GLITCH (STRT_GLITCH),
    .PAR_ERR     (PAR_ERR),
    .STP_ERR     (STP_ERR),
    .EDGE_CNT    (EDGE_CNT),
    .BIT_CNT     (BIT_CNT),
    .DAT_SAMP_EN (DAT_SAMP_EN),
    .STRT_CHK_EN (STRT_CHK_EN),
    .PAR_CHK_EN  (PAR_CHK_EN),
    .STP_CHK_EN  (STP_CHK_EN),
    .P_DATA      (P_DATA),
    .DATA_VALID  (DATA_VALID),
    .PAR_ERR_FLAG(PAR_ERR_FLAG),
    .FRM_ERR_FLAG(FRM_ERR_FLAG)
  );

  always #5 CLK = ~CLK;

  int         checks = 0;
  int         errors = 0;

  // Reference model state carried between frames.
  logic [7:0] exp_pdata = 8'h00;  // value P_DATA holds outside shifting
  bit         pend = 1'b0;        // a frame result is due in the next cycle
  logic [2:0] pend_res = 3'b000;  // {DATA_VALID, PAR_ERR_FLAG, FRM_ERR_FLAG}

  // Effective oversampling ratio for a PRESCALE value.
  function automatic int eff_p(input int presc);
    return (presc == 8 || presc == 16 || presc == 32) ? presc : 8;
  endfunction

  // Idle line for n cycles; the first cycle shows any pending frame result.
  task automatic idle_cycles(input string tag, input int n);
    for (int c = 0; c < n; c++) begin
      @(negedge CLK);
      RST         = 1'b0;
      RX_IN       = 1'b1;
      PRESCALE    = 6'($urandom_range(0, 63));
      PAR_EN      = 1'($urandom);
      SAMPLED_BIT = 1'($urandom);
      STRT_GLITCH = 1'($urandom);
      PAR_ERR     = 1'($urandom);
      STP_ERR     = 1'($urandom);
      #1;
      checks += 5;
      if (EDGE_CNT !== 6'd0) begin
        errors++;
        $display("FAIL %s idle edge_cnt cyc=%0d got=%0d exp=0", tag, c, EDGE_CNT);
      end
      if (BIT_CNT !== 4'd0) begin
        errors++;
        $display("FAIL %s idle bit_cnt cyc=%0d got=%0d exp=0", tag, c, BIT_CNT);
      end
      if ({DAT_SAMP_EN, STRT_CHK_EN, PAR_CHK_EN, STP_CHK_EN} !== 4'b0000) begin
        errors++;
        $display("FAIL %s idle strobes cyc=%0d got=%b exp=0000", tag, c,
                 {DAT_SAMP_EN, STRT_CHK_EN, PAR_CHK_EN, STP_CHK_EN});
      end
      if ({DATA_VALID, PAR_ERR_FLAG, FRM_ERR_FLAG} !== (pend ? pend_res : 3'b000)) begin
        errors++;
        $display("FAIL %s idle result cyc=%0d got=%b exp=%b", tag, c,
                 {DATA_VALID, PAR_ERR_FLAG, FRM_ERR_FLAG}, pend ? pend_res : 3'b000);
      end
      if (P_DATA !== exp_pdata) begin
        errors++;
        $display("FAIL %s idle p_data cyc=%0d got=%h exp=%h", tag, c, P_DATA, exp_pdata);
      end
      pend = 1'b0;
    end
  endtask

  // Drive one frame starting this cycle and check every cycle of it.
  // abort_at >= 0 asserts RST in that cycle offset; mid_presc > 0 forces the
  // PRESCALE value shown after the start cycle, otherwise it is random.
  task automatic run_frame(input string tag, input logic [7:0] data, input int presc,
                           input logic par_en, input logic perr, input logic serr,
                           input logic glitch, input int abort_at, input int mid_presc);
    int         p;
    int         len;
    int         k;
    int         idx;
    int         full;
    logic [7:0] old;
    logic [7:0] e_pdata;
    logic [3:0] e_strb;
    logic [2:0] e_res;
    bit         aborted;
    p       = eff_p(presc);
    len     = glitch ? p : (par_en ? 11 * p : 10 * p);
    old     = exp_pdata;
    aborted = 1'b0;
    for (int o = 0; o < len; o++) begin
      @(negedge CLK);
      RST         = (o == abort_at);
      RX_IN       = (o == 0) ? 1'b0 : 1'($urandom);
      PRESCALE    = (o == 0) ? 6'(presc) :
                    (mid_presc > 0 ? 6'(mid_presc) : 6'($urandom_range(0, 63)));
      PAR_EN      = (o == 0) ? par_en : 1'($urandom);
      SAMPLED_BIT = 1'($urandom);
      STRT_GLITCH = 1'($urandom);
      PAR_ERR     = 1'($urandom);
      STP_ERR     = 1'($urandom);
      idx = o / p - 1;
      if (o == p - 1) STRT_GLITCH = glitch;
      if (!glitch && (o % p == p - 1) && idx >= 0 && idx < 8) SAMPLED_BIT = data[idx];
      if (!glitch && par_en && o == 10 * p - 1) PAR_ERR = perr;
      if (!glitch && o == len - 1) STP_ERR = serr;
      #1;
      // Bits shifted in so far: data bit i is captured at the end of bit i+1.
      k = o / p - 1;
      if (k < 0) k = 0;
      if (k > 8) k = 8;
      full    = (int'(old) >> k) | ((int'(data) & ((1 << k) - 1)) << (8 - k));
      e_pdata = full[7:0];
      e_strb  = {o != 0, o == p - 1, !glitch && par_en && o == 10 * p - 1,
                 !glitch && o == len - 1};
      e_res   = (o == 0 && pend) ? pend_res : 3'b000;
      checks += 5;
      if (EDGE_CNT !== 6'(o % p)) begin
        errors++;
        $display("FAIL %s edge_cnt off=%0d got=%0d exp=%0d", tag, o, EDGE_CNT, o % p);
      end
      if (BIT_CNT !== 4'(o / p)) begin
        errors++;
        $display("FAIL %s bit_cnt off=%0d got=%0d exp=%0d", tag, o, BIT_CNT, o / p);
      end
      if ({DAT_SAMP_EN, STRT_CHK_EN, PAR_CHK_EN, STP_CHK_EN} !== e_strb) begin
        errors++;
        $display("FAIL %s strobes(samp,strt,par,stp) off=%0d got=%b exp=%b", tag, o,
                 {DAT_SAMP_EN, STRT_CHK_EN, PAR_CHK_EN, STP_CHK_EN}, e_strb);
      end
      if ({DATA_VALID, PAR_ERR_FLAG, FRM_ERR_FLAG} !== e_res) begin
        errors++;
        $display("FAIL %s result(dv,pe,fe) off=%0d got=%b exp=%b", tag, o,
                 {DATA_VALID, PAR_ERR_FLAG, FRM_ERR_FLAG}, e_res);
      end
      if (P_DATA !== e_pdata) begin
        errors++;
        $display("FAIL %s p_data off=%0d got=%h exp=%h", tag, o, P_DATA, e_pdata);
      end
      pend = 1'b0;
      if (o == abort_at) begin
        aborted = 1'b1;
        break;
      end
    end
    if (aborted) begin
      exp_pdata = 8'h00;
      pend      = 1'b0;
      idle_cycles({tag, "_after_rst"}, 2);
    end else if (!glitch) begin
      pend      = 1'b1;
      pend_res  = {!(par_en && perr) && !serr, par_en && perr, serr};
      exp_pdata = data;
    end
  endtask

  task automatic test_reset();
    for (int c = 0; c < 3; c++) begin
      @(negedge CLK);
      RST   = 1'b1;
      RX_IN = 1'($urandom);
      #1;
      checks += 3;
      if ({EDGE_CNT, BIT_CNT} !== 10'd0) begin
        errors++;
        $display("FAIL reset counters cyc=%0d got=%h exp=0", c, {EDGE_CNT, BIT_CNT});
      end
      if ({DAT_SAMP_EN, STRT_CHK_EN, PAR_CHK_EN, STP_CHK_EN,
           DATA_VALID, PAR_ERR_FLAG, FRM_ERR_FLAG} !== 7'd0) begin
        errors++;
        $display("FAIL reset strobes_flags cyc=%0d got=%b exp=0", c,
                 {DAT_SAMP_EN, STRT_CHK_EN, PAR_CHK_EN, STP_CHK_EN,
                  DATA_VALID, PAR_ERR_FLAG, FRM_ERR_FLAG});
      end
      if (P_DATA !== 8'h00) begin
        errors++;
        $display("FAIL reset p_data cyc=%0d got=%h exp=00", c, P_DATA);
      end
    end
    exp_pdata = 8'h00;
    pend      = 1'b0;
    idle_cycles("post_reset", 2);
  endtask

  task automatic test_parity_frame();
    run_frame("a5_p8_par", 8'hA5, 8, 1'b1, 1'b0, 1'b0, 1'b0, -1, 0);
    idle_cycles("a5_end", 3);
  endtask

  task automatic test_no_parity();
    run_frame("3c_p16_nopar", 8'h3C, 16, 1'b0, 1'b0, 1'b0, 1'b0, -1, 0);
    idle_cycles("3c_end", 2);
  endtask

  task automatic test_glitch();
    run_frame("glitch_p8", 8'h00, 8, 1'b1, 1'b0, 1'b0, 1'b1, -1, 0);
    run_frame("55_after_glitch", 8'h55, 8, 1'b1, 1'b0, 1'b0, 1'b0, -1, 0);
    idle_cycles("55_end", 2);
  endtask

  task automatic test_errors();
    run_frame("01_par_err", 8'h01, 8, 1'b1, 1'b1, 1'b0, 1'b0, -1, 0);
    idle_cycles("par_err_end", 2);
    run_frame("01_stp_err", 8'h01, 8, 1'b1, 1'b0, 1'b1, 1'b0, -1, 0);
    idle_cycles("stp_err_end", 2);
    run_frame("01_both_err", 8'h01, 8, 1'b1, 1'b1, 1'b1, 1'b0, -1, 0);
    idle_cycles("both_err_end", 2);
  endtask

  task automatic test_back_to_back();
    run_frame("12_p32_b2b", 8'h12, 32, 1'b1, 1'b0, 1'b0, 1'b0, -1, 8);
    run_frame("34_p32_b2b", 8'h34, 32, 1'b1, 1'b0, 1'b0, 1'b0, -1, 8);
    idle_cycles("b2b_end", 2);
  endtask

  task automatic test_reset_midframe();
    run_frame("c3_rst_bit4", 8'hC3, 8, 1'b1, 1'b0, 1'b0, 1'b0, 32, 0);
    run_frame("ff_after_rst", 8'hFF, 8, 1'b1, 1'b0, 1'b0, 1'b0, -1, 0);
    idle_cycles("ff_end", 1);
    run_frame("9a_presc10", 8'h9A, 10, 1'b0, 1'b0, 1'b0, 1'b0, -1, 0);
    idle_cycles("presc10_end", 2);
  endtask

  task automatic test_random();
    for (int n = 0; n < 24; n++) begin
      int   sel;
      int   presc;
      int   gap;
      logic glitch;
      sel    = $urandom_range(0, 3);
      presc  = (sel == 0) ? 8 : (sel == 1) ? 16 : (sel == 2) ? 32 : $urandom_range(0, 63);
      glitch = ($urandom_range(0, 5) == 0);
      run_frame("rand", 8'($urandom), presc, 1'($urandom),
                $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0, glitch, -1, 0);
      gap = $urandom_range(0, 2);
      if (gap > 0) idle_cycles("rand_gap", gap);
    end
    idle_cycles("rand_end", 2);
  endtask

  initial begin
    test_reset();
    test_parity_frame();
    test_no_parity();
    test_glitch();
    test_errors();
    test_back_to_back();
    test_reset_midframe();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_rx_ctrl.md
Name: uart_rx_ctrl

Overview:
Receive-side sequencer for the UART RX path. It detects the start bit and runs per-bit edge and bit counters. It enables the data sampler and the start, parity and stop checkers at fixed edges, and shifts sampled bits into an internal LSB-first deserializer. It publishes P_DATA with a one-cycle DATA_VALID only for error-free frames. It sits between the oversampling data sampler and the checker blocks in the RX clock domain.

Parameters:
DATA_WIDTH, 8, payload bits per frame (deserializer width, bit_cnt terminal value)
PRESCALE_W, 6, width of PRESCALE input

Ports:
CLK  input  1  RX oversampling clock
RST  input  1  synchronous, active-high reset
RX_IN  input  1  serial line, idle high
PAR_EN  input  1  1 = frame carries a parity bit
PRESCALE  input  PRESCALE_W  oversampling ratio; supported 8, 16, 32
SAMPLED_BIT  input  1  majority-voted bit from data sampler, valid at last edge of each bit
STRT_GLITCH  input  1  start checker result, combinational on STRT_CHK_EN
PAR_ERR  input  1  parity checker result, combinational on PAR_CHK_EN
STP_ERR  input  1  stop checker result, combinational on STP_CHK_EN
EDGE_CNT  output  PRESCALE_W  current oversample edge within bit (to sampler)
BIT_CNT  output  4  current bit index within frame
DAT_SAMP_EN  output  1  sampler enable
STRT_CHK_EN  output  1  start-check strobe
PAR_CHK_EN  output  1  parity-check strobe
STP_CHK_EN  output  1  stop-check strobe
P_DATA  output  DATA_WIDTH  deserialized payload (feeds parity checker)
DATA_VALID  output  1  one-cycle pulse, P_DATA valid
PAR_ERR_FLAG  output  1  one-cycle pulse at frame end, parity failed
FRM_ERR_FLAG  output  1  one-cycle pulse at frame end, stop bit failed

Behaviour:
- Reset (RST=1 at posedge): state=IDLE. EDGE_CNT, BIT_CNT, P_DATA, all strobes, DATA_VALID and flags are 0. Latched prescale is 8. Reset mid-frame aborts the frame with no DATA_VALID and no flags.
- States: IDLE, START, DATA, PARITY, STOP.
- IDLE: DAT_SAMP_EN=0. If RX_IN=0:
  - latch PRESCALE (unsupported values latch as 8);
  - this cycle is edge 0 of the start bit; next cycle state=START, EDGE_CNT=1.
- In every non-IDLE state: DAT_SAMP_EN=1. EDGE_CNT increments each cycle and wraps from P-1 to 0 (P = latched prescale). The wrap marks a bit boundary and BIT_CNT increments on it. PRESCALE changes mid-frame are ignored.
- All check strobes are single-cycle and assert only when EDGE_CNT=P-1. The matching checker result is sampled in that same cycle.
- START: STRT_CHK_EN at edge P-1.
  - STRT_GLITCH=1: go to IDLE, counters cleared, no flags.
  - Otherwise: go to DATA.
- DATA: at each edge P-1, shift SAMPLED_BIT into P_DATA MSB side (right shift), so the first data bit ends in P_DATA[0]. After DATA_WIDTH bits, go to PARITY if PAR_EN=1, else STOP. PAR_EN is latched with the prescale.
- PARITY: PAR_CHK_EN at edge P-1. PAR_ERR=1 sets an internal parity-fail bit. Go to STOP regardless.
- STOP: STP_CHK_EN at edge P-1. The next cycle:
  - state=IDLE, counters=0;
  - DATA_VALID=1 only if parity-fail=0 and STP_ERR=0;
  - PAR_ERR_FLAG / FRM_ERR_FLAG pulse for the respective failures (both may pulse together);
  - the fail bit clears.
- P_DATA holds its value until the next frame's first data shift.
- Latency: start-detect cycle t is edge 0.
  - Parity frame: stop check at t+11P-1, DATA_VALID at t+11P (P=8: t+88).
  - No-parity frame: DATA_VALID at t+10P (P=8: t+80).
- Back-to-back: in the DATA_VALID cycle the state is IDLE. RX_IN=0 in that cycle starts the next frame with no dead cycle.
- RX_IN is not monitored outside IDLE except through the checkers.

Test Plan:
- P=8, PAR_EN=1, byte 0xA5 LSB-first, correct parity, stop=1 -> P_DATA=0xA5; DATA_VALID pulse at t+88; no flags; strobes seen only at EDGE_CNT=7.
- P=16, PAR_EN=0, byte 0x3C -> DATA_VALID at t+160; PAR_CHK_EN never asserts.
- Glitch: RX_IN low 3 cycles at P=8, STRT_GLITCH=1 at start check -> return to IDLE at t+8; no DATA_VALID; next real frame of 0x55 received correctly.
- Parity and stop errors: P=8, byte 0x01, PAR_ERR=1 -> PAR_ERR_FLAG pulse at t+88, DATA_VALID=0. Repeat with STP_ERR=1 -> FRM_ERR_FLAG only.
- Back-to-back frames 0x12 then 0x34 with no idle gap at P=32 -> two DATA_VALID pulses 352 cycles apart with correct payloads. PRESCALE changed to 8 mid first frame has no effect.
- RST asserted at BIT_CNT=4 -> next cycle state IDLE, all outputs 0. A fresh frame 0xFF then completes normally. PRESCALE=10 -> frame timed as P=8.
